// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage 8-bit pipeline: stage enables, bubbles and ALU forwarding.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_idex_rs1,
    input  logic [1:0] i_idex_rs2,
    input  logic [1:0] i_ifid_rs1,
    input  logic [1:0] i_ifid_rs2,
    input  logic       i_ifid_use_rs1,
    input  logic       i_ifid_use_rs2,
    input  logic [1:0] i_idex_rd,
    input  logic       i_idex_reg_en,
    input  logic       i_idex_is_load,
    input  logic [1:0] i_exm_rd,
    input  logic       i_exm_reg_en,
    input  logic       i_exm_mem_req,
    input  logic       i_mem_ready,
    input  logic [1:0] i_memwb_rd,
    input  logic       i_memwb_reg_en,
    input  logic       i_branch_taken,
    output logic       o_pc_en,
    output logic       o_ifid_en,
    output logic       o_idex_en,
    output logic       o_exm_en,
    output logic       o_ifid_flush,
    output logic       o_idex_flush,
    output logic [1:0] o_fwd_a_sel,
    output logic [1:0] o_fwd_b_sel,
    output logic       o_mem_err,
    output logic [1:0] o_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0] o_stall_cycles,
    output logic [15:0] o_flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_t;

    localparam logic [7:0] L_TIMEOUT      = 8'(MEM_TIMEOUT);
    localparam logic [1:0] L_FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_flush_cnt;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    logic       w_mem_stall;
    logic       w_timeout;
    logic       w_flushing;
    logic       w_load_use;
    logic       w_lu_stall;
    logic [1:0] w_next_flush_cnt;

    assign w_mem_stall = i_exm_mem_req & ~i_mem_ready & (r_wait_cnt < L_TIMEOUT);
    assign w_timeout   = i_exm_mem_req & ~i_mem_ready & ~w_mem_stall;
    assign w_flushing  = (r_flush_cnt != 2'd0);
    assign w_load_use  = i_idex_is_load & i_idex_reg_en &
                         ((i_ifid_use_rs1 & (i_idex_rd == i_ifid_rs1)) |
                          (i_ifid_use_rs2 & (i_idex_rd == i_ifid_rs2)));
    // Load-use is keyed on the flush counter, not on RUN, so the release cycle of a
    // memory wait still protects a real dependency; ID holds a bubble while flushing.
    assign w_lu_stall  = w_load_use & ~w_flushing & ~w_mem_stall & ~i_branch_taken;

    // The flush counter freezes under a memory stall and resumes on release.
    assign w_next_flush_cnt = i_branch_taken ? L_FLUSH_RELOAD :
                              w_flushing     ? r_flush_cnt - 2'd1 : 2'd0;

    function automatic logic [1:0] fwd_sel(input logic [1:0] rs, input logic exm_en_wb,
                                           input logic [1:0] exm_rd, input logic wb_en,
                                           input logic [1:0] wb_rd);
        if (exm_en_wb && exm_rd == rs) return 2'b01;
        if (wb_en && wb_rd == rs)      return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_idex_en    = 1'b1;
        o_exm_en     = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_fwd_a_sel  = fwd_sel(i_idex_rs1, i_exm_reg_en, i_exm_rd, i_memwb_reg_en, i_memwb_rd);
        o_fwd_b_sel  = fwd_sel(i_idex_rs2, i_exm_reg_en, i_exm_rd, i_memwb_reg_en, i_memwb_rd);
        if (rst) begin
            {o_pc_en, o_ifid_en, o_idex_en, o_exm_en} = 4'b0000;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_fwd_a_sel  = 2'b00;
            o_fwd_b_sel  = 2'b00;
        end else if (w_mem_stall) begin
            {o_pc_en, o_ifid_en, o_idex_en, o_exm_en} = 4'b0000;
        end else if (i_branch_taken) begin
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_flushing) begin
            o_ifid_flush = 1'b1;
        end else if (w_lu_stall) begin
            o_pc_en      = 1'b0;
            o_ifid_en    = 1'b0;
            o_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
        if (rst) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 2'd0;
            r_wait_cnt  <= 8'd0;
            r_mem_err   <= 1'b0;
        end else if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt  <= 8'd0;
            r_flush_cnt <= w_next_flush_cnt;
            r_state     <= (w_next_flush_cnt != 2'd0) ? ST_FLUSH : ST_RUN;
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    assign o_mem_err = r_mem_err;
    assign o_state   = r_state;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
            r_flush_cycles <= 16'd0;
        end else begin
            if ((w_mem_stall | w_lu_stall) && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (o_ifid_flush && r_flush_cycles != 16'hFFFF)
                r_flush_cycles <= r_flush_cycles + 16'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage 8-bit pipeline: IF, ID, EX, MEM, WB.
- Generates register enables and flushes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Generates operand-forwarding selects for the EX-stage ALU.
- Sequences load-use stalls, taken-branch flushes and multi-cycle data-memory waits, with a memory timeout.

Parameters:
- FLUSH_CYCLES, 2: total cycles IF/ID is flushed after a taken branch. Legal range 1-4.
- MEM_TIMEOUT, 15: maximum consecutive cycles spent waiting for mem_ready before the access is abandoned. Legal range 2-255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- idex_rs1 / idex_rs2  in  2  source registers of the instruction in EX
- ifid_rs1 / ifid_rs2  in  2  source registers of the instruction in ID
- ifid_use_rs1 / ifid_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- idex_rd  in  2  destination register of the EX instruction
- idex_reg_en  in  1  EX instruction writes a register
- idex_is_load  in  1  EX instruction is a load
- exm_rd  in  2  EX/MEM destination register (ra_out)
- exm_reg_en  in  1  EX/MEM write-back enable
- exm_mem_req  in  1  MEM stage performs a data access
- mem_ready  in  1  data memory completes the access this cycle
- memwb_rd  in  2  MEM/WB destination register
- memwb_reg_en  in  1  MEM/WB write-back enable
- branch_taken  in  1  EX resolved a taken branch
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID register enable
- idex_en  out  1  ID/EX register enable
- exm_en  out  1  EX/MEM register enable
- ifid_flush  out  1  IF/ID register loads a bubble
- idex_flush  out  1  ID/EX register loads a bubble
- fwd_a_sel / fwd_b_sel  out  2  ALU operand source: 00 = ID/EX register value, 01 = EX/MEM ALU_out, 10 = WB data
- mem_err  out  1  sticky memory-timeout flag
- state  out  2  00 = RUN, 01 = FLUSH, 10 = MEM_WAIT

Behaviour:
- Reset (rst sampled high):
  - state = RUN; flush counter = 0; wait counter = 0; mem_err = 0.
  - While rst is high: all enables = 0, ifid_flush = idex_flush = 1, fwd selects = 00.
- Forwarding (combinational):
  - fwd_a_sel = 01 if exm_reg_en and exm_rd == idex_rs1.
  - Otherwise 10 if memwb_reg_en and memwb_rd == idex_rs1.
  - Otherwise 00.
  - EX/MEM wins over WB. Register 0 is not special. fwd_b_sel is identical using idex_rs2.
- Hazard terms:
  - mem_stall = exm_mem_req & ~mem_ready & (wait counter < MEM_TIMEOUT).
  - load_use = idex_is_load & idex_reg_en & ((ifid_use_rs1 & idex_rd == ifid_rs1) | (ifid_use_rs2 & idex_rd == ifid_rs2)).
- Priority: mem_stall > branch_taken > load_use.
- mem_stall:
  - All four enables = 0; no flushes.
  - state -> MEM_WAIT; wait counter increments each cycle.
- Access completion: the cycle mem_ready goes high, enables = 1 and the pipeline advances. Next state is RUN and the wait counter clears.
- Timeout: when the wait counter reaches MEM_TIMEOUT, mem_stall drops and the pipeline advances (access abandoned). mem_err is set and stays set until rst. The wait counter clears.
- branch_taken with no mem_stall:
  - ifid_flush = idex_flush = 1; all enables = 1.
  - If FLUSH_CYCLES > 1: enter FLUSH and load the flush counter with FLUSH_CYCLES - 1.
- FLUSH state:
  - ifid_flush = 1 and the flush counter decrements each cycle; return to RUN at 0.
  - mem_stall freezes the counter and has priority.
  - A new branch_taken reloads the counter.
  - load_use is ignored, since ID holds a bubble.
- load_use in RUN with no higher-priority event:
  - pc_en = ifid_en = 0; idex_flush = 1; exm_en = 1.
  - Lasts one cycle and needs no state; the load has advanced by the next cycle.
- Branch held during a memory wait: branch_taken asserted during mem_stall is held by the frozen EX stage and acted on in the release cycle.
- Default outputs: all enables = 1, flushes = 0.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Extra outputs stall_cycles[15:0] and flush_cycles[15:0].
  - stall_cycles increments on every cycle with mem_stall or load_use; flush_cycles increments on every cycle with ifid_flush = 1 outside reset.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: both ports are absent and no counter logic is generated.

Test Plan:
- Reset release: rst held 3 cycles, then dropped -> state = 00, all enables = 1, flushes = 0, mem_err = 0.
- Forwarding: exm_rd = 2, exm_reg_en = 1, memwb_rd = 2, memwb_reg_en = 1, idex_rs1 = 2, idex_rs2 = 3 -> fwd_a_sel = 01, fwd_b_sel = 00. Then drop exm_reg_en -> fwd_a_sel = 10.
- Load-use: idex_is_load = 1, idex_rd = 1, ifid_rs2 = 1, ifid_use_rs2 = 1 -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1; the next cycle is clean.
- Branch: branch_taken pulsed 1 cycle with FLUSH_CYCLES = 2 -> ifid_flush = 1 for 2 cycles, idex_flush = 1 for the first cycle only, state FLUSH for 1 cycle.
- Memory wait plus branch: exm_mem_req = 1, mem_ready low 4 cycles, branch_taken = 1 throughout -> enables = 0 for 4 cycles, state = 10. In the release cycle, flushes assert and the FLUSH sequence follows.
- Timeout: MEM_TIMEOUT = 15, mem_ready never asserted -> 15 frozen cycles, then advance, mem_err = 1 until rst.
